// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings and FSM state type.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Lane extraction/extension for loads, lane merge for sub-word stores, alignment check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  input  logic [15:0] wdata,
  output logic [31:0] load_ext,
  output logic [31:0] store_merged,
  output logic        misaligned
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = word >> {addr, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = addr[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    load_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_ext = {24'h0, byte_sel};
      F3_H:    load_ext = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_ext = {16'h0, half_sel};
      F3_W:    load_ext = word;
      default: load_ext = 32'h0;
    endcase

    // Untouched lanes keep the value just read from memory.
    store_merged = word;
    case (funct3)
      F3_B: store_merged[{addr, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (addr[1]) store_merged[31:16] = wdata;
        else         store_merged[15:0]  = wdata;
      end
      default: store_merged = word;
    endcase

    misaligned = (((funct3 == F3_H) || (funct3 == F3_HU)) && addr[0]) ||
                 ((funct3 == F3_W) && (addr != 2'b00));
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request in flight, word-only dmem, read-modify-write for sb/sh.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_a,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS) << 2;

  lsu_state_t  state;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;
  logic [31:0] wr_data_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [2:0]  align_f3;
  logic [1:0]  align_addr;
  logic [31:0] load_ext;
  logic [31:0] store_merged;
  logic        misaligned;
  logic        illegal;
  logic        req_error;
  logic        in_mem_phase;

  // In IDLE the aligner judges the incoming request; afterwards it works on the latched one.
  assign align_f3   = (state == IDLE) ? req_funct3    : f3_q;
  assign align_addr = (state == IDLE) ? req_addr[1:0] : addr_q[1:0];

  lsu_align u_align (
    .word         (mem_rd),
    .addr         (align_addr),
    .funct3       (align_f3),
    .wdata        (wdata_q),
    .load_ext     (load_ext),
    .store_merged (store_merged),
    .misaligned   (misaligned)
  );

  always_comb begin
    if (req_we) illegal = req_funct3[2] || (req_funct3 == 3'b011);
    else        illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                          (req_funct3 == 3'b111);
    req_error = illegal || misaligned || (req_addr >= ADDR_LIMIT);
  end

  assign in_mem_phase = (state == LOAD) || (state == RMW_RD) || (state == WRITE);
  assign req_ready    = (state == IDLE) && reset_n;
  assign rsp_valid    = (state == RESP) && reset_n;
  assign rsp_rdata    = reset_n ? rdata_q : 32'h0;
  assign rsp_err      = reset_n && err_q;
  assign mem_we       = (state == WRITE) && reset_n;
  assign mem_a        = (in_mem_phase && reset_n) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wd       = mem_we ? wr_data_q : 32'h0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      f3_q      <= 3'b000;
      addr_q    <= 32'h0;
      wdata_q   <= 16'h0;
      wr_data_q <= 32'h0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            f3_q      <= req_funct3;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata[15:0];
            wr_data_q <= req_wdata;
            if (req_error) begin
              rdata_q <= 32'h0;
              err_q   <= 1'b1;
              state   <= RESP;
            end else if (req_we) begin
              state <= (req_funct3 == F3_W) ? WRITE : RMW_RD;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          rdata_q <= load_ext;
          err_q   <= 1'b0;
          state   <= RESP;
        end
        RMW_RD: begin
          wr_data_q <= store_merged;
          state     <= WRITE;
        end
        WRITE: begin
          rdata_q <= 32'h0;
          err_q   <= 1'b0;
          state   <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed table-driven bench for load_store_unit with a small word-addressed dmem model.
module tb_load_store_unit;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] dmem [64];

  int applied;
  int miscompares;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wecyc;
    int          word_idx;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[15];

  load_store_unit #(.MEM_WORDS(64)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_a      (mem_a),
    .mem_we     (mem_we),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd = dmem[mem_a[7:2]];

  always @(posedge clk) begin
    if (mem_we) dmem[mem_a[7:2]] <= mem_wd;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Issues one request, then counts cycles after the transfer edge until rsp_valid.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, output int lat,
                               output logic [31:0] rdata, output logic err,
                               output int wes, output int wecyc);
    int waited;
    lat = 0; rdata = 32'hDEAD_BEEF; err = 1'bx; wes = 0; wecyc = 0; waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (mem_we) begin
        wes++;
        wecyc = n;
      end
      if (rsp_valid) begin
        lat   = n;
        rdata = rsp_rdata;
        err   = rsp_err;
        break;
      end
    end
  endtask

  initial begin
    int          lat, wes, wecyc;
    logic [31:0] rd;
    logic        er;
    int          ready_cyc, rsp1_cyc, rsp2_cyc;
    logic [31:0] rsp2_data;
    logic        saw_rsp, saw_we, bad_ready;

    applied = 0;
    miscompares = 0;
    for (int i = 0; i < 64; i++) dmem[i] = 32'h0;
    dmem[1] = 32'h1122_3344;
    dmem[2] = 32'h80FF_7F01;

    //            name       we    f3      addr    wdata         rdata        err  lat wec idx word
    vecs[0]  = '{"lw08",    1'b0, 3'b010, 32'h08, 32'h0,        32'h80FF7F01, 1'b0, 2, 0, -1, 32'h0};
    vecs[1]  = '{"lb08",    1'b0, 3'b000, 32'h08, 32'h0,        32'h00000001, 1'b0, 2, 0, -1, 32'h0};
    vecs[2]  = '{"lb0B",    1'b0, 3'b000, 32'h0B, 32'h0,        32'hFFFFFF80, 1'b0, 2, 0, -1, 32'h0};
    vecs[3]  = '{"lbu0B",   1'b0, 3'b100, 32'h0B, 32'h0,        32'h00000080, 1'b0, 2, 0, -1, 32'h0};
    vecs[4]  = '{"lh0A",    1'b0, 3'b001, 32'h0A, 32'h0,        32'hFFFF80FF, 1'b0, 2, 0, -1, 32'h0};
    vecs[5]  = '{"lhu0A",   1'b0, 3'b101, 32'h0A, 32'h0,        32'h000080FF, 1'b0, 2, 0, -1, 32'h0};
    vecs[6]  = '{"lh08",    1'b0, 3'b001, 32'h08, 32'h0,        32'h00007F01, 1'b0, 2, 0, -1, 32'h0};
    vecs[7]  = '{"sb05",    1'b1, 3'b000, 32'h05, 32'hFFFFFFAB, 32'h0,        1'b0, 3, 2,  1, 32'h1122AB44};
    vecs[8]  = '{"sh06",    1'b1, 3'b001, 32'h06, 32'h0000BEEF, 32'h0,        1'b0, 3, 2,  1, 32'hBEEFAB44};
    vecs[9]  = '{"lw06err", 1'b0, 3'b010, 32'h06, 32'h0,        32'h0,        1'b1, 1, 0, -1, 32'h0};
    vecs[10] = '{"lh03err", 1'b0, 3'b001, 32'h03, 32'h0,        32'h0,        1'b1, 1, 0, -1, 32'h0};
    vecs[11] = '{"f3_011",  1'b0, 3'b011, 32'h08, 32'h0,        32'h0,        1'b1, 1, 0, -1, 32'h0};
    vecs[12] = '{"lw100",   1'b0, 3'b010, 32'h100,32'h0,        32'h0,        1'b1, 1, 0, -1, 32'h0};
    vecs[13] = '{"st_f3_4", 1'b1, 3'b100, 32'h08, 32'h12345678, 32'h0,        1'b1, 1, 0,  2, 32'h80FF7F01};
    vecs[14] = '{"sw10",    1'b1, 3'b010, 32'h10, 32'h76543210, 32'h0,        1'b0, 2, 1,  4, 32'h76543210};

    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", {31'h0, req_ready}, 32'h0);
    checkOutput("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    checkOutput("rst_rdata", rsp_rdata, 32'h0);
    checkOutput("rst_mem_we", {31'h0, mem_we}, 32'h0);
    checkOutput("rst_mem_a", mem_a, 32'h0);
    checkOutput("rst_mem_wd", mem_wd, 32'h0);
    reset_n = 1'b1;
    #1 checkOutput("post_rst_ready", {31'h0, req_ready}, 32'h1);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, rd, er, wes, wecyc);
      checkOutput({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
      checkOutput({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      checkOutput({vecs[i].name, "_err"}, {31'h0, er}, {31'h0, vecs[i].exp_err});
      checkOutput({vecs[i].name, "_we_count"}, 32'(wes), (vecs[i].exp_wecyc != 0) ? 32'd1 : 32'd0);
      checkOutput({vecs[i].name, "_we_cycle"}, 32'(wecyc), 32'(vecs[i].exp_wecyc));
      if (vecs[i].word_idx >= 0) begin
        @(negedge clk);
        checkOutput({vecs[i].name, "_word"}, dmem[vecs[i].word_idx], vecs[i].exp_word);
      end
    end

    // Reset asserted during the WRITE cycle of an sb must suppress the write and the response.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h04;
    req_wdata  = 32'h0000_0055;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_mem_we", {31'h0, mem_we}, 32'h0);
    saw_rsp = 1'b0;
    saw_we  = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
      if (mem_we) saw_we = 1'b1;
    end
    reset_n = 1'b1;
    #1;
    checkOutput("rst_mid_ready", {31'h0, req_ready}, 32'h1);
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
      if (mem_we) saw_we = 1'b1;
    end
    checkOutput("rst_mid_no_rsp", {31'h0, saw_rsp}, 32'h0);
    checkOutput("rst_mid_no_we", {31'h0, saw_we}, 32'h0);
    checkOutput("rst_mid_word1", dmem[1], 32'hBEEFAB44);

    // Back-to-back: req_valid stays high, sw then lw to the same word.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h0C;
    req_wdata  = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    req_we    = 1'b0;
    req_wdata = 32'h0;
    ready_cyc = 0; rsp1_cyc = 0; rsp2_cyc = 0; rsp2_data = 32'h0; bad_ready = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (rsp_valid && rsp1_cyc == 0) rsp1_cyc = n;
      else if (rsp_valid && rsp2_cyc == 0) begin
        rsp2_cyc  = n;
        rsp2_data = rsp_rdata;
      end
      if (req_ready && ready_cyc == 0) begin
        ready_cyc = n;
        @(posedge clk);
        #1 req_valid = 1'b0;
      end else if (req_ready && rsp1_cyc == 0) begin
        bad_ready = 1'b1;
      end
      if (rsp2_cyc != 0) break;
    end
    req_valid = 1'b0;
    checkOutput("b2b_sw_rsp_cycle", 32'(rsp1_cyc), 32'd2);
    checkOutput("b2b_ready_cycle", 32'(ready_cyc), 32'd3);
    checkOutput("b2b_early_ready", {31'h0, bad_ready}, 32'h0);
    checkOutput("b2b_lw_rsp_cycle", 32'(rsp2_cyc), 32'd5);
    checkOutput("b2b_lw_data", rsp2_data, 32'hCAFEF00D);
    checkOutput("b2b_word3", dmem[3], 32'hCAFEF00D);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
